// File: rtl/multi_port_charge_controller.sv
// Multi-outlet coin charger: one shared keypad front-end FSM feeding per-outlet minute countdown timers.
// Build option CHARGE_TOPUP_EN: when defined, a commit may top up an outlet that is already charging.
module multi_port_charge_controller #(
    parameter int PORTS        = 2,
    parameter int MONEY_W      = 5,
    parameter int TIME_W       = 6,
    parameter int MAX_MONEY    = 20,
    parameter int UNIT_TIME    = 2,
    parameter int TICK_DIV     = 60000,
    parameter int IDLE_TIMEOUT = 10,
    localparam int SEL_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              key_value,
    input  logic                    press,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    confirm,
    output logic                    no_display,
    output logic [MONEY_W-1:0]      all_money,
    output logic [SEL_W-1:0]        sel_port,
    output logic [PORTS*TIME_W-1:0] remaining_time,
    output logic [PORTS-1:0]        charging,
    output logic [2:0]              current_state
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ACT_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam int CALC_W = MONEY_W + 4;

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [ACT_W-1:0]  ACT_LAST   = ACT_W'(IDLE_TIMEOUT - 1);
    localparam logic [4:0]        PORT_LIMIT = 5'(PORTS);
    localparam logic [CALC_W-1:0] MONEY_CAP  = CALC_W'(MAX_MONEY);
    localparam logic [CALC_W-1:0] TEN        = CALC_W'(10);
    localparam logic [3:0]        KEY_MAX    = 4'd9;
    localparam logic [31:0]       UNIT_K     = UNIT_TIME;
    localparam logic [TIME_W-1:0] TIME_MAX   = '1;
    localparam logic [31:0]       TIME_MAX_W = 32'(TIME_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_INPUT  = 3'd2,
        S_COMMIT = 3'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [MONEY_W-1:0]      money_q, money_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [ACT_W-1:0]        act_q, act_d;
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [PORTS*TIME_W-1:0] timers_q, timers_d;
    logic                    no_disp_q, no_disp_d;
    // Delayed copies of {press, clear, start, confirm} for rising-edge detection.
    logic [3:0]              btn_q, btn_d;

    logic                    ev_press, ev_clear, ev_start, ev_confirm, any_ev;
    logic                    tick, timeout, commit;
    logic                    key_is_port, port_free;
    logic [CALC_W-1:0]       money_calc;
    logic [31:0]             add_amt, sum_t;
    logic [TIME_W-1:0]       cur_t;

    assign ev_press   = press   & ~btn_q[3];
    assign ev_clear   = clear   & ~btn_q[2];
    assign ev_start   = start   & ~btn_q[1];
    assign ev_confirm = confirm & ~btn_q[0];
    assign any_ev     = ev_press | ev_clear | ev_confirm;

    assign tick       = (presc_q == PRE_LAST);
    assign commit     = (state_q == S_COMMIT);
    assign money_calc = CALC_W'(money_q) * TEN + CALC_W'(key_value);
    assign add_amt    = 32'(money_q) * UNIT_K;

    assign key_is_port = ({1'b0, key_value} < PORT_LIMIT);
`ifdef CHARGE_TOPUP_EN
    assign port_free = 1'b1;
`else
    // Without top-up, a busy outlet cannot be selected, so a commit always lands on an idle timer.
    assign port_free = ~charging[key_value[SEL_W-1:0]];
`endif

    // Inactivity counter only runs while a user session is open.
    always_comb begin
        act_d   = '0;
        timeout = 1'b0;
        if (state_q == S_SELECT || state_q == S_INPUT) begin
            act_d = act_q;
            if (any_ev) begin
                act_d = '0;
            end else if (tick) begin
                if (act_q == ACT_LAST) begin
                    timeout = 1'b1;
                    act_d   = '0;
                end else begin
                    act_d = act_q + ACT_W'(1);
                end
            end
        end
    end

    always_comb begin
        btn_d   = {press, clear, start, confirm};
        state_d = state_q;
        money_d = money_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                money_d = '0;
                if (ev_start) begin
                    if (PORTS == 1) begin
                        sel_d   = '0;
                        state_d = S_INPUT;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (ev_clear) begin
                    state_d = S_IDLE;
                end else if (!ev_confirm && ev_press) begin
                    if (key_is_port && port_free) begin
                        sel_d   = key_value[SEL_W-1:0];
                        state_d = S_INPUT;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    money_d = '0;
                end
            end
            S_INPUT: begin
                if (ev_clear) begin
                    money_d = '0;
                end else if (ev_confirm) begin
                    if (money_q != '0) begin
                        state_d = S_COMMIT;
                    end
                end else if (ev_press) begin
                    if (key_value <= KEY_MAX) begin
                        money_d = (money_calc > MONEY_CAP) ? MONEY_CAP[MONEY_W-1:0]
                                                           : money_calc[MONEY_W-1:0];
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    money_d = '0;
                end
            end
            S_COMMIT: begin
                money_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                money_d = '0;
                state_d = S_IDLE;
            end
        endcase
        no_disp_d = (state_d == S_IDLE);
    end

    // Commit is applied first, then the minute tick, so a coinciding tick trims the fresh sum.
    always_comb begin
        presc_d  = tick ? '0 : presc_q + PRE_W'(1);
        timers_d = timers_q;
        cur_t    = '0;
        sum_t    = '0;
        for (int i = 0; i < PORTS; i++) begin
            cur_t = timers_q[i*TIME_W +: TIME_W];
            if (commit && (sel_q == SEL_W'(i))) begin
`ifdef CHARGE_TOPUP_EN
                sum_t = 32'(cur_t) + add_amt;
`else
                sum_t = add_amt;
`endif
                cur_t = (sum_t > TIME_MAX_W) ? TIME_MAX : sum_t[TIME_W-1:0];
            end
            if (tick && (cur_t != '0)) begin
                cur_t = cur_t - TIME_W'(1);
            end
            timers_d[i*TIME_W +: TIME_W] = cur_t;
        end
    end

    always_comb begin
        charging = '0;
        for (int i = 0; i < PORTS; i++) begin
            charging[i] = |timers_q[i*TIME_W +: TIME_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            money_q   <= '0;
            sel_q     <= '0;
            act_q     <= '0;
            presc_q   <= '0;
            timers_q  <= '0;
            no_disp_q <= 1'b1;
            btn_q     <= '0;
        end else begin
            state_q   <= state_d;
            money_q   <= money_d;
            sel_q     <= sel_d;
            act_q     <= act_d;
            presc_q   <= presc_d;
            timers_q  <= timers_d;
            no_disp_q <= no_disp_d;
            btn_q     <= btn_d;
        end
    end

    assign no_display     = no_disp_q;
    assign all_money      = money_q;
    assign sel_port       = sel_q;
    assign remaining_time = timers_q;
    assign current_state  = state_q;

endmodule

// File: tb/tb_multi_port_charge_controller.sv
// Randomized bench for multi_port_charge_controller (PORTS=2, TICK_DIV=10, IDLE_TIMEOUT=3)
// against a behavioural model of the keypad session and outlet timers.
module tb_multi_port_charge_controller;

    localparam int PORTS        = 2;
    localparam int MONEY_W      = 5;
    localparam int TIME_W       = 6;
    localparam int MAX_MONEY    = 20;
    localparam int UNIT_TIME    = 2;
    localparam int TICK_DIV     = 10;
    localparam int IDLE_TIMEOUT = 3;
    localparam int TMAX         = (1 << TIME_W) - 1;
    localparam int W            = 22;
`ifdef CHARGE_TOPUP_EN
    localparam bit TOPUP = 1'b1;
`else
    localparam bit TOPUP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] key_value = '0;
    logic press = 1'b0, clear = 1'b0, start = 1'b0, confirm = 1'b0;

    logic                    no_display;
    logic [MONEY_W-1:0]      all_money;
    logic [0:0]              sel_port;
    logic [PORTS*TIME_W-1:0] remaining_time;
    logic [PORTS-1:0]        charging;
    logic [2:0]              current_state;

    always #5 clk = ~clk;

    multi_port_charge_controller #(
        .PORTS(PORTS), .MONEY_W(MONEY_W), .TIME_W(TIME_W), .MAX_MONEY(MAX_MONEY),
        .UNIT_TIME(UNIT_TIME), .TICK_DIV(TICK_DIV), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_value(key_value), .press(press), .clear(clear),
        .start(start), .confirm(confirm), .no_display(no_display), .all_money(all_money),
        .sel_port(sel_port), .remaining_time(remaining_time), .charging(charging),
        .current_state(current_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // Session: 0 idle, 1 choosing outlet, 2 keying money, 3 committing.
    int m_state, m_money, m_sel, m_idle, m_presc;
    int m_timer[PORTS];
    bit m_pp, m_pc, m_ps, m_pf;

    task automatic model_reset();
        m_state = 0; m_money = 0; m_sel = 0; m_idle = 0; m_presc = 0;
        for (int i = 0; i < PORTS; i++) m_timer[i] = 0;
        m_pp = 0; m_pc = 0; m_ps = 0; m_pf = 0;
        exp_q.delete();
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        bit ev_p, ev_c, ev_s, ev_f, tk, to, was_commit;
        int k, old_sel, add, t;
        ev_p = press && !m_pp;
        ev_c = clear && !m_pc;
        ev_s = start && !m_ps;
        ev_f = confirm && !m_pf;
        m_pp = press; m_pc = clear; m_ps = start; m_pf = confirm;
        k = int'(key_value);
        tk = (m_presc == TICK_DIV - 1);
        m_presc = (m_presc + 1) % TICK_DIV;
        was_commit = (m_state == 3);
        old_sel = m_sel;
        add = m_money * UNIT_TIME;

        to = 0;
        if (m_state == 1 || m_state == 2) begin
            if (ev_p || ev_c || ev_f) m_idle = 0;
            else if (tk) begin
                m_idle++;
                if (m_idle >= IDLE_TIMEOUT) begin
                    to = 1;
                    m_idle = 0;
                end
            end
        end else m_idle = 0;

        case (m_state)
            0: begin
                m_money = 0;
                if (ev_s) m_state = 1;
            end
            1: begin
                if (ev_c) m_state = 0;
                else if (ev_f) begin end
                else if (ev_p) begin
                    if (k < PORTS) begin
                        if (TOPUP || m_timer[k] == 0) begin
                            m_sel = k;
                            m_state = 2;
                        end
                    end
                end else if (to) begin
                    m_state = 0;
                    m_money = 0;
                end
            end
            2: begin
                if (ev_c) m_money = 0;
                else if (ev_f) begin
                    if (m_money != 0) m_state = 3;
                end else if (ev_p) begin
                    if (k <= 9) m_money = min_i(m_money * 10 + k, MAX_MONEY);
                end else if (to) begin
                    m_state = 0;
                    m_money = 0;
                end
            end
            default: begin
                m_money = 0;
                m_state = 0;
            end
        endcase

        for (int i = 0; i < PORTS; i++) begin
            t = m_timer[i];
            if (was_commit && old_sel == i) t = TOPUP ? min_i(t + add, TMAX) : min_i(add, TMAX);
            if (tk && t > 0) t = t - 1;
            m_timer[i] = t;
        end

        exp_q.push_back({3'(m_state), (m_state == 0), 5'(m_money), 1'(m_sel),
                         6'(m_timer[1]), 6'(m_timer[0])});
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("state", 32'(current_state), 32'(e[21:19]));
            check_eq("no_display", 32'(no_display), 32'(e[18]));
            check_eq("all_money", 32'(all_money), 32'(e[17:13]));
            check_eq("sel_port", 32'(sel_port), 32'(e[12]));
            check_eq("remaining_time", 32'(remaining_time), 32'(e[11:0]));
            check_eq("charging", 32'(charging), {30'd0, e[11:6] != 6'd0, e[5:0] != 6'd0});
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_state"}, 32'(current_state), 32'd0);
        check_eq({tag, "_no_display"}, 32'(no_display), 32'd1);
        check_eq({tag, "_all_money"}, 32'(all_money), 32'd0);
        check_eq({tag, "_sel_port"}, 32'(sel_port), 32'd0);
        check_eq({tag, "_remaining_time"}, 32'(remaining_time), 32'd0);
        check_eq({tag, "_charging"}, 32'(charging), 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_n(input int n);
        repeat (n) step();
    endtask

    // which: 0 press, 1 clear, 2 start, 3 confirm
    task automatic pulse_btn(input int which, input int k, input int hold);
        key_value = 4'(k);
        case (which)
            0: press = 1'b1;
            1: clear = 1'b1;
            2: start = 1'b1;
            default: confirm = 1'b1;
        endcase
        repeat (hold) step();
        press = 1'b0; clear = 1'b0; start = 1'b0; confirm = 1'b0;
        step();
    endtask

    task automatic key(input int k);
        pulse_btn(0, k, 1);
    endtask

    task automatic do_reset();
        press = 1'b0; clear = 1'b0; start = 1'b0; confirm = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_outlet(input int port, input int digit);
        pulse_btn(2, 0, 1);
        key(port);
        key(digit);
        pulse_btn(3, 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int tgt, op, guard;
        #2;
        do_reset();

        // Basic session: outlet 1, 12 money -> 24 minutes.
        pulse_btn(2, 0, 1);
        key(1);
        key(1);
        key(2);
        check_eq("money_12", 32'(all_money), 32'd12);
        pulse_btn(3, 0, 1);
        check_eq("commit_charging", 32'(charging), 32'b10);
        check_eq("commit_idle", 32'(current_state), 32'd0);

        // Clamp, clear, and confirm with zero money.
        pulse_btn(2, 0, 1);
        key(0);
        key(9);
        key(9);
        check_eq("money_clamp", 32'(all_money), 32'(MAX_MONEY));
        pulse_btn(1, 0, 1);
        check_eq("money_cleared", 32'(all_money), 32'd0);
        pulse_btn(3, 0, 1);
        check_eq("confirm_zero_stays", 32'(current_state), 32'd2);

        // Outlet 0 loaded with 4 minutes and allowed to run out.
        key(2);
        pulse_btn(3, 0, 1);
        idle_n(60);
        check_eq("outlet0_empty", 32'(remaining_time[5:0]), 32'd0);
        check_eq("outlet1_still_on", 32'(charging[1]), 32'd1);

`ifdef CHARGE_TOPUP_EN
        pulse_btn(2, 0, 1); key(0); key(2); key(0); pulse_btn(3, 0, 1);
        pulse_btn(2, 0, 1); key(0); key(2); key(0); pulse_btn(3, 0, 1);
        check_eq("topup_saturated", 32'(remaining_time[5:0] >= 6'd62), 32'd1);
`else
        pulse_btn(2, 0, 1);
        key(1);
        check_eq("busy_select_ignored", 32'(current_state), 32'd1);
        pulse_btn(1, 0, 1);
`endif

        // Inactivity timeout while keying money.
        pulse_btn(2, 0, 1);
        key(0);
        idle_n(35);
        check_eq("timeout_idle", 32'(current_state), 32'd0);
        check_eq("timeout_money", 32'(all_money), 32'd0);

        // Commit lands on the same edge as a minute tick.
        tgt = TOPUP ? 1 : 0;
        pulse_btn(2, 0, 1);
        key(tgt);
        key(2);
        guard = 0;
        while (m_presc != TICK_DIV - 2 && guard < 20) begin
            step();
            guard++;
        end
        check_eq("align_bound", 32'(guard < 20), 32'd1);
        pulse_btn(3, 0, 1);

        // Randomized sessions.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: pulse_btn(2, 0, $urandom_range(1, 3));
                2, 3, 4, 5: pulse_btn(0, $urandom_range(0, 11), $urandom_range(1, 3));
                6: pulse_btn(1, 0, $urandom_range(1, 2));
                7, 8: pulse_btn(3, 0, $urandom_range(1, 3));
                default: idle_n($urandom_range(1, 15));
            endcase
        end

        // Asynchronous reset mid-session with both outlets charging.
        do_reset();
        load_outlet(0, 9);
        load_outlet(1, 9);
        pulse_btn(2, 0, 1);
        if (TOPUP) begin
            key(0);
            key(5);
        end
        check_eq("both_charging", 32'(charging), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle_n(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
